// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared pinmux reset-sequencer state encoding, default delays and helpers
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    P_WAIT = 3'd1,
    C_WAIT = 3'd2,
    S_WAIT = 3'd3,
    RUN    = 3'd4,
    SOFT   = 3'd5
  } seq_state_e;

  localparam int DEF_P_DLY  = 4;
  localparam int DEF_C_DLY  = 4;
  localparam int DEF_S_DLY  = 4;
  localparam int DEF_SR_DLY = 8;
  localparam int DEF_CNT_W  = 8;

  localparam int STICKY_SOFT_REBOOT_BIT = 31;

  // Terminal count for a delay: zero is treated as one, and adj edges are absorbed elsewhere.
  function automatic int dly_term(input int dly, input int adj);
    int eff;
    eff = (dly < 1) ? 1 : dly;
    return (eff - adj < 0) ? 0 : eff - adj;
  endfunction

endpackage

// File: rtl/reset_sequencer_reset_sync.sv
// rtl/reset_sequencer_reset_sync.sv - 2-flop async-assert / sync-deassert synchronizer (reset value 0)
module reset_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered p_reset_n / clk_enb / s_reset_n release with soft-reboot servicing
// Optional watchdog full-sequence restart: define RESET_SEQ_WDT_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int P_DLY  = DEF_P_DLY,
  parameter int C_DLY  = DEF_C_DLY,
  parameter int S_DLY  = DEF_S_DLY,
  parameter int SR_DLY = DEF_SR_DLY,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       e_reset_n,
  input  logic       soft_reboot_req,
`ifdef RESET_SEQ_WDT_EN
  input  logic       wdt_reset_req,
`endif
  output logic       p_reset_n,
  output logic       clk_enb,
  output logic       s_reset_n,
  output logic       soft_reboot_done,
  output logic [2:0] seq_state
);

  // The RST exit edge is the first of the P_DLY edges, so P_WAIT holds one edge less.
  localparam logic [CNT_W-1:0] L_P_TERM  = CNT_W'(dly_term(P_DLY, 2));
  localparam logic [CNT_W-1:0] L_C_TERM  = CNT_W'(dly_term(C_DLY, 1));
  localparam logic [CNT_W-1:0] L_S_TERM  = CNT_W'(dly_term(S_DLY, 1));
  localparam logic [CNT_W-1:0] L_SR_TERM = CNT_W'(dly_term(SR_DLY, 1));
  localparam bit               L_P_SKIP  = (P_DLY <= 1);

  logic             w_rst_sync_n;
  logic             w_req_sync;
  logic             w_req_rise;
  logic             w_wdt;
  logic             r_req_d;
  logic             r_soft_pass;
  logic             r_p_reset_n;
  logic             r_clk_enb;
  logic             r_s_reset_n;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  seq_state_e       r_state;

  reset_sync u_rst_sync (
    .i_clk   (clk),
    .i_rst_n (e_reset_n),
    .i_d     (1'b1),
    .o_q     (w_rst_sync_n)
  );

  reset_sync u_req_sync (
    .i_clk   (clk),
    .i_rst_n (e_reset_n),
    .i_d     (soft_reboot_req),
    .o_q     (w_req_sync)
  );

`ifdef RESET_SEQ_WDT_EN
  assign w_wdt = wdt_reset_req;
`else
  assign w_wdt = 1'b0;
`endif

  // Edge tracker runs in every state so a level held across a sequence never retriggers.
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) r_req_d <= 1'b0;
    else            r_req_d <= w_req_sync;
  end

  assign w_req_rise = w_req_sync & ~r_req_d;

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      r_state     <= RST;
      r_cnt       <= '0;
      r_p_reset_n <= 1'b0;
      r_clk_enb   <= 1'b0;
      r_s_reset_n <= 1'b0;
      r_done      <= 1'b0;
      r_soft_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wdt && (r_state != RST)) begin
        r_p_reset_n <= 1'b0;
        r_clk_enb   <= 1'b0;
        r_s_reset_n <= 1'b0;
        r_soft_pass <= 1'b0;
        r_cnt       <= '0;
        r_state     <= P_WAIT;
      end else begin
        case (r_state)
          RST: begin
            if (w_rst_sync_n) begin
              r_cnt <= '0;
              if (L_P_SKIP) begin
                r_p_reset_n <= 1'b1;
                r_state     <= C_WAIT;
              end else begin
                r_state <= P_WAIT;
              end
            end
          end
          P_WAIT: begin
            if (r_cnt == L_P_TERM) begin
              r_p_reset_n <= 1'b1;
              r_cnt       <= '0;
              r_state     <= C_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          C_WAIT: begin
            if (r_cnt == L_C_TERM) begin
              r_clk_enb <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (r_cnt == L_S_TERM) begin
              r_s_reset_n <= 1'b1;
              r_done      <= r_soft_pass;
              r_soft_pass <= 1'b0;
              r_cnt       <= '0;
              r_state     <= RUN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (w_req_rise) begin
              r_s_reset_n <= 1'b0;
              r_clk_enb   <= 1'b0;
              r_soft_pass <= 1'b1;
              r_cnt       <= '0;
              r_state     <= SOFT;
            end
          end
          SOFT: begin
            if (r_cnt == L_SR_TERM) begin
              r_cnt   <= '0;
              r_state <= C_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= RST;
          end
        endcase
      end
    end
  end

  assign p_reset_n        = r_p_reset_n;
  assign clk_enb          = r_clk_enb;
  assign s_reset_n        = r_s_reset_n;
  assign soft_reboot_done = r_done;
  assign seq_state        = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - vector tables, corner sequences and randomized timeline-model checks
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int P = 4, C = 4, S = 4, SR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic e_reset_n = 1'b0;
  logic soft_reboot_req = 1'b0;
`ifdef RESET_SEQ_WDT_EN
  logic wdt_reset_req = 1'b0;
`endif
  logic       p_reset_n, clk_enb, s_reset_n, soft_reboot_done;
  logic [2:0] seq_state;
  logic       p0_reset_n, clk0_enb, s0_reset_n, soft0_done;
  logic [2:0] seq0_state;

  reset_sequencer #(.P_DLY(P), .C_DLY(C), .S_DLY(S), .SR_DLY(SR), .CNT_W(8)) dut (
    .clk(clk), .e_reset_n(e_reset_n), .soft_reboot_req(soft_reboot_req),
`ifdef RESET_SEQ_WDT_EN
    .wdt_reset_req(wdt_reset_req),
`endif
    .p_reset_n(p_reset_n), .clk_enb(clk_enb), .s_reset_n(s_reset_n),
    .soft_reboot_done(soft_reboot_done), .seq_state(seq_state)
  );

  reset_sequencer #(.P_DLY(0), .C_DLY(C), .S_DLY(S), .SR_DLY(SR), .CNT_W(8)) dut0 (
    .clk(clk), .e_reset_n(e_reset_n), .soft_reboot_req(soft_reboot_req),
`ifdef RESET_SEQ_WDT_EN
    .wdt_reset_req(wdt_reset_req),
`endif
    .p_reset_n(p0_reset_n), .clk_enb(clk0_enb), .s_reset_n(s0_reset_n),
    .soft_reboot_done(soft0_done), .seq_state(seq0_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: outputs follow from the edge count since release and the edge a reboot began.
  int   m_n = 0;
  int   m_soft = -1;
  bit   m_chk = 1'b1;
  logic m_hist[$];

  function automatic seq_state_e mstate(input int n);
    int d;
    if (m_soft < 0 || n < m_soft) begin
      if (n <= 2)             return RST;
      if (n < 2 + P)          return P_WAIT;
      if (n < 2 + P + C)      return C_WAIT;
      if (n < 2 + P + C + S)  return S_WAIT;
      return RUN;
    end
    d = n - m_soft;
    if (d < SR)          return SOFT;
    if (d < SR + C)      return C_WAIT;
    if (d < SR + C + S)  return S_WAIT;
    return RUN;
  endfunction

  always @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      m_n = 0;
      m_soft = -1;
      m_hist.delete();
      m_hist.push_back(1'b0);
    end else begin
      m_n++;
      m_hist.push_back(soft_reboot_req);
      if (m_n >= 3 && m_hist[m_n-2] && !m_hist[m_n-3] && mstate(m_n - 1) == RUN)
        m_soft = m_n;
    end
  end

  task automatic check_model();
    seq_state_e st;
    st = mstate(m_n);
    chk("model p_reset_n", {7'd0, p_reset_n}, {7'd0, !(st == RST || st == P_WAIT)});
    chk("model clk_enb",   {7'd0, clk_enb},   {7'd0, (st == S_WAIT || st == RUN)});
    chk("model s_reset_n", {7'd0, s_reset_n}, {7'd0, (st == RUN)});
    chk("model done",      {7'd0, soft_reboot_done}, {7'd0, (m_soft >= 0 && m_n == m_soft + SR + C + S)});
    chk("model seq_state", {5'd0, seq_state}, {5'd0, st});
  endtask

  always @(posedge clk) if (m_chk) begin #1; check_model(); end

  typedef struct {
    int         e;
    logic       p, c, s, d, p0;
    seq_state_e st;
  } vec_t;
  vec_t tbl[$];

  task automatic run_table(input int lo, input int hi, input int n_edges, input string tag);
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk); #1;
      if (soft_reboot_done) done_seen++;
      for (int i = lo; i <= hi; i++) if (tbl[i].e == e) begin
        chk({tag, " p_reset_n"}, {7'd0, p_reset_n}, {7'd0, tbl[i].p});
        chk({tag, " clk_enb"},   {7'd0, clk_enb},   {7'd0, tbl[i].c});
        chk({tag, " s_reset_n"}, {7'd0, s_reset_n}, {7'd0, tbl[i].s});
        chk({tag, " done"},      {7'd0, soft_reboot_done}, {7'd0, tbl[i].d});
        chk({tag, " seq_state"}, {5'd0, seq_state}, {5'd0, tbl[i].st});
        chk({tag, " p0_reset_n"}, {7'd0, p0_reset_n}, {7'd0, tbl[i].p0});
      end
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, " p_reset_n"}, {7'd0, p_reset_n}, 8'd0);
    chk({tag, " clk_enb"},   {7'd0, clk_enb},   8'd0);
    chk({tag, " s_reset_n"}, {7'd0, s_reset_n}, 8'd0);
    chk({tag, " seq_state"}, {5'd0, seq_state}, {5'd0, RST});
  endtask

  int rst_hold;
  int run_wait;

  initial begin
    // Power-on timeline from e_reset_n release (edge 1 is the first edge after release).
    tbl.push_back('{1,  0, 0, 0, 0, 0, RST});
    tbl.push_back('{2,  0, 0, 0, 0, 0, RST});
    tbl.push_back('{3,  0, 0, 0, 0, 1, P_WAIT});
    tbl.push_back('{5,  0, 0, 0, 0, 1, P_WAIT});
    tbl.push_back('{6,  1, 0, 0, 0, 1, C_WAIT});
    tbl.push_back('{9,  1, 0, 0, 0, 1, C_WAIT});
    tbl.push_back('{10, 1, 1, 0, 0, 1, S_WAIT});
    tbl.push_back('{13, 1, 1, 0, 0, 1, S_WAIT});
    tbl.push_back('{14, 1, 1, 1, 0, 1, RUN});
    tbl.push_back('{15, 1, 1, 1, 0, 1, RUN});
    // Soft reboot timeline from the request rising (edge 1 samples it).
    tbl.push_back('{2,  1, 1, 1, 0, 1, RUN});
    tbl.push_back('{3,  1, 0, 0, 0, 1, SOFT});
    tbl.push_back('{10, 1, 0, 0, 0, 1, SOFT});
    tbl.push_back('{11, 1, 0, 0, 0, 1, C_WAIT});
    tbl.push_back('{14, 1, 0, 0, 0, 1, C_WAIT});
    tbl.push_back('{15, 1, 1, 0, 0, 1, S_WAIT});
    tbl.push_back('{18, 1, 1, 0, 0, 1, S_WAIT});
    tbl.push_back('{19, 1, 1, 1, 1, 1, RUN});
    tbl.push_back('{20, 1, 1, 1, 0, 1, RUN});

    repeat (3) @(posedge clk);
    #1 chk_all_low("reset");
    chk("reset done", {7'd0, soft_reboot_done}, 8'd0);

    @(negedge clk) e_reset_n = 1'b1;
    run_table(0, 9, 15, "poweron");

    @(negedge clk) soft_reboot_req = 1'b1;
    done_seen = 0;
    run_table(10, 18, 20, "soft");
    run_table(0, -1, 15, "hold");
    chk("hold no retrigger state", {5'd0, seq_state}, {5'd0, RUN});
    chk("hold done count", 8'(done_seen), 8'd1);
    @(negedge clk) soft_reboot_req = 1'b0;
    repeat (4) @(posedge clk);

    @(negedge clk) e_reset_n = 1'b0;
    @(negedge clk) e_reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #3 e_reset_n = 1'b0;
    #1 chk_all_low("async cwait");
    @(negedge clk) e_reset_n = 1'b1;
    run_table(0, 9, 15, "restart1");

    @(negedge clk) soft_reboot_req = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("in soft", {5'd0, seq_state}, {5'd0, SOFT});
    #2 e_reset_n = 1'b0;
    #1 chk_all_low("async soft");
    soft_reboot_req = 1'b0;
    @(negedge clk) e_reset_n = 1'b1;
    run_table(0, 9, 15, "restart2");

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (e_reset_n) begin
        if ($urandom_range(0, 299) == 0) begin
          e_reset_n = 1'b0;
          rst_hold = $urandom_range(1, 4);
        end
      end else begin
        rst_hold--;
        if (rst_hold <= 0) e_reset_n = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) soft_reboot_req = ~soft_reboot_req;
    end

`ifdef RESET_SEQ_WDT_EN
    @(negedge clk) begin m_chk = 1'b0; soft_reboot_req = 1'b0; e_reset_n = 1'b0; end
    @(negedge clk) e_reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk) begin wdt_reset_req = 1'b1; soft_reboot_req = 1'b1; end
    @(posedge clk); #1;
    chk("wdt p_reset_n", {7'd0, p_reset_n}, 8'd0);
    chk("wdt clk_enb",   {7'd0, clk_enb},   8'd0);
    chk("wdt s_reset_n", {7'd0, s_reset_n}, 8'd0);
    chk("wdt seq_state", {5'd0, seq_state}, {5'd0, P_WAIT});
    @(negedge clk) wdt_reset_req = 1'b0;
    done_seen = 0;
    run_wait = 0;
    while (seq_state != RUN && run_wait < 60) begin
      @(posedge clk); #1;
      if (soft_reboot_done) done_seen++;
      run_wait++;
    end
    chk("wdt reaches run", {5'd0, seq_state}, {5'd0, RUN});
    repeat (10) begin
      @(posedge clk); #1;
      if (soft_reboot_done) done_seen++;
    end
    chk("wdt no done", 8'(done_seen), 8'd0);
    chk("wdt still run", {5'd0, seq_state}, {5'd0, RUN});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates the ordered reset and clock-enable release sequence consumed by the strap and core logic: power-on reset, then clock enable, then soft reset. Sits in the pinmux/glue domain beside the strap controller. It also services the software soft-reboot request carried in sticky-strap bit 31 by re-running the clock/soft-reset part of the sequence, leaving power-on reset and sticky straps untouched.

## Interface
- P_DLY, 4: cycles from synchronized external reset release to p_reset_n release (1..2^CNT_W-1).
- C_DLY, 4: cycles from p_reset_n release to clk_enb assertion.
- S_DLY, 4: cycles from clk_enb assertion to s_reset_n release.
- SR_DLY, 8: cycles soft reset and clock gating are held during a soft reboot.
- CNT_W, 8: delay counter width.

- clk  in  1  system clock.
- e_reset_n  in  1  external reset; one clock; reset is asynchronous and active-low.
- soft_reboot_req  in  1  soft-reboot request (sticky-strap bit 31), asynchronous to clk.
- p_reset_n  out  1  power-on reset to strap/sticky logic, active-low.
- clk_enb  out  1  system clock enable.
- s_reset_n  out  1  soft reset to core, active-low.
- soft_reboot_done  out  1  one-cycle pulse on return to RUN after a soft reboot.
- seq_state  out  3  current FSM state, debug.

## Operation
- e_reset_n passes through a 2-flop synchronizer: asynchronous assert, synchronous deassert (rst_sync_n).
- While e_reset_n low: all outputs 0, FSM in RST, counter 0, request sync flops 0.
- States: RST -> P_WAIT -> C_WAIT -> S_WAIT -> RUN; RUN -> SOFT -> C_WAIT.
- RST: leave to P_WAIT when rst_sync_n = 1.
- P_WAIT: count P_DLY; then p_reset_n <= 1, go C_WAIT.
- C_WAIT: count C_DLY; then clk_enb <= 1, go S_WAIT.
- S_WAIT: count S_DLY; then s_reset_n <= 1, go RUN.
- RUN: soft_reboot_req double-synchronized, rising edge detected. On edge: s_reset_n <= 0 and clk_enb <= 0 in same cycle, go SOFT.
- SOFT: count SR_DLY; then go C_WAIT; p_reset_n stays 1 throughout.
- soft_reboot_done pulses the cycle s_reset_n returns to 1 after a SOFT pass; never after power-on sequence.
- Delay value 0 is treated as 1. Counter clears on every state change; saturates never (terminal compare on DLY-1).
- Request edges outside RUN are ignored; edge detector keeps tracking so a level held through the sequence does not retrigger.
- Request is level-held by the strap logic and cleared by s_reset_n low; no explicit ack.

## Timing
- Outputs are registered; every transition is on a clk rising edge.
- rst_sync_n rises on 2nd clk edge after e_reset_n deasserts.
- p_reset_n rises P_DLY edges after rst_sync_n; clk_enb C_DLY after p_reset_n; s_reset_n S_DLY after clk_enb.
- Request-to-s_reset_n-low latency: 3 cycles (2 sync + edge detect) after request becomes stable.
- Soft reboot: s_reset_n low for SR_DLY + C_DLY + S_DLY cycles; clk_enb low for SR_DLY + C_DLY.
- e_reset_n assertion in any state: all outputs 0 asynchronously, FSM to RST.

## Configuration
- RESET_SEQ_WDT_EN defined: adds input wdt_reset_req (1 bit, synchronous pulse). In any state except RST, a pulse drives p_reset_n, clk_enb, s_reset_n to 0 next cycle and enters P_WAIT (full sequence, sticky straps reloaded). Takes priority over soft-reboot edge.
- Not defined: port absent; only e_reset_n causes a full sequence.

## Structure
- Shared pinmux package: state enum (RST, P_WAIT, C_WAIT, S_WAIT, RUN, SOFT), default delay constants, sticky-strap soft-reboot bit index.
- One sub-module: reset_sync (2-flop async-assert/sync-deassert synchronizer), also reused for request synchronization with reset value 0.

## Test plan
- Defaults, e_reset_n released: p_reset_n rises edge 6, clk_enb edge 10, s_reset_n edge 14; seq_state reaches RUN.
- In RUN raise soft_reboot_req: s_reset_n/clk_enb low 3 cycles later, p_reset_n stays 1; clk_enb back after 12 cycles, s_reset_n after 16, soft_reboot_done one pulse.
- Hold soft_reboot_req high through entire reboot: exactly one reboot, no retrigger.
- Assert e_reset_n mid C_WAIT and mid SOFT: all outputs 0 immediately; re-release restarts full sequence with same timing.
- P_DLY=0: p_reset_n rises 1 edge after rst_sync_n.
- With RESET_SEQ_WDT_EN, pulse wdt_reset_req in RUN while soft_reboot_req rises: all outputs low next cycle, full P_WAIT sequence, no soft_reboot_done.
